// File: rtl/hazard_pkg.sv
// Shared definitions for the multi-cycle hazard controller: operand forward-select
// codes and the MUL/DIV wait FSM state encoding.
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_MC_WAIT = 1'b1
   } hz_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one Execute operand: the youngest in-flight producer (Memory)
// wins over Writeback; x0 never forwards.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] rse,
   input  logic [AW-1:0] rdm,
   input  logic [AW-1:0] rdw,
   input  logic          regwritem,
   input  logic          regwritew,
   output logic [1:0]    fwd
);

   localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};

   logic mem_hit_s;
   logic wb_hit_s;

   assign mem_hit_s = regwritem & (rse != REG_ZERO) & (rse == rdm);
   assign wb_hit_s  = regwritew & (rse != REG_ZERO) & (rse == rdw);

   // Priority select of the operand source.
   always_comb begin
      fwd = FWD_RF;
      if (mem_hit_s) begin
         fwd = FWD_MEM;
      end else if (wb_hit_s) begin
         fwd = FWD_WB;
      end else begin
         fwd = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller with MUL/DIV wait FSM (timeout) and data-memory stall.
// Optional saturating performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl_mc
   import hazard_pkg::*;
#(
   parameter int AW         = 5,
   parameter int MC_TIMEOUT = 64,
   parameter int PERF_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     rs1d,
   input  logic [AW-1:0]     rs2d,
   input  logic [AW-1:0]     rs1e,
   input  logic [AW-1:0]     rs2e,
   input  logic [AW-1:0]     rde,
   input  logic [AW-1:0]     rdm,
   input  logic [AW-1:0]     rdw,
   input  logic              regwritem,
   input  logic              regwritew,
   input  logic              resultsrce0,
   input  logic              pcsrce,
   input  logic              memreadm,
   input  logic              dmem_ready,
   input  logic              mc_start_e,
   input  logic              mc_done,
   output logic              mc_go,
   output logic              mc_err,
   output logic [1:0]        forwardae,
   output logic [1:0]        forwardbe,
   output logic              stallf,
   output logic              stalld,
   output logic              stalle,
   output logic              stallm,
   output logic              flushd,
   output logic              flushe,
   output logic              flushm,
   output logic              flushw,
   output logic [PERF_W-1:0] perf_stall,
   output logic [PERF_W-1:0] perf_flush,
   output logic [PERF_W-1:0] perf_mc
);

   localparam int              TW         = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [TW-1:0]   TIMER_LAST = TW'(MC_TIMEOUT - 1);
   localparam logic [AW-1:0]   REG_ZERO   = {AW{1'b0}};

   hz_state_e     state_r;
   hz_state_e     state_nx_s;
   logic [TW-1:0] timer_r;
   logic [TW-1:0] timer_nx_s;
   logic          init_r;

   logic          memstall_s;
   logic          lwstall_s;
   logic [1:0]    fwd_a_s;
   logic [1:0]    fwd_b_s;
   logic          stallf_s, stalld_s, stalle_s, stallm_s;
   logic          flushd_s, flushe_s, flushm_s, flushw_s;
   logic          mc_go_s, mc_err_s;

   hazard_fwd_sel #(.AW(AW)) u_fwd_a (
      .rse       (rs1e),
      .rdm       (rdm),
      .rdw       (rdw),
      .regwritem (regwritem),
      .regwritew (regwritew),
      .fwd       (fwd_a_s)
   );

   hazard_fwd_sel #(.AW(AW)) u_fwd_b (
      .rse       (rs2e),
      .rdm       (rdm),
      .rdw       (rdw),
      .regwritem (regwritem),
      .regwritew (regwritew),
      .fwd       (fwd_b_s)
   );

   assign memstall_s = memreadm & ~dmem_ready;
   assign lwstall_s  = resultsrce0 & (rde != REG_ZERO) & ((rs1d == rde) | (rs2d == rde));

   // Prioritised stall/flush decode and FSM next-state; init_r low means the
   // pipeline is still held in its reset bubble state.
   always_comb begin
      stallf_s   = 1'b0;
      stalld_s   = 1'b0;
      stalle_s   = 1'b0;
      stallm_s   = 1'b0;
      flushd_s   = 1'b0;
      flushe_s   = 1'b0;
      flushm_s   = 1'b0;
      flushw_s   = 1'b0;
      mc_go_s    = 1'b0;
      mc_err_s   = 1'b0;
      state_nx_s = state_r;
      timer_nx_s = timer_r;
      if (!init_r) begin
         flushd_s = 1'b1;
         flushe_s = 1'b1;
         flushm_s = 1'b1;
         flushw_s = 1'b1;
      end else if (memstall_s) begin
         stallf_s = 1'b1;
         stalld_s = 1'b1;
         stalle_s = 1'b1;
         stallm_s = 1'b1;
         flushw_s = 1'b1;
      end else if (state_r == ST_MC_WAIT) begin
         if (mc_done) begin
            state_nx_s = ST_IDLE;
         end else if (timer_r != TIMER_LAST) begin
            stallf_s   = 1'b1;
            stalld_s   = 1'b1;
            stalle_s   = 1'b1;
            flushm_s   = 1'b1;
            timer_nx_s = timer_r + TW'(1);
         end else begin
            mc_err_s   = 1'b1;
            state_nx_s = ST_IDLE;
         end
      end else if (mc_start_e) begin
         mc_go_s    = 1'b1;
         stallf_s   = 1'b1;
         stalld_s   = 1'b1;
         stalle_s   = 1'b1;
         flushm_s   = 1'b1;
         timer_nx_s = {TW{1'b0}};
         state_nx_s = ST_MC_WAIT;
      end else if (pcsrce) begin
         flushd_s = 1'b1;
         flushe_s = 1'b1;
      end else if (lwstall_s) begin
         stallf_s = 1'b1;
         stalld_s = 1'b1;
         flushe_s = 1'b1;
      end else begin
         state_nx_s = state_r;
      end
   end

   // FSM state, MUL/DIV wait timer and reset-release marker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         timer_r <= {TW{1'b0}};
         init_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         timer_r <= timer_nx_s;
         init_r  <= 1'b1;
      end
   end

   assign forwardae = init_r ? fwd_a_s : FWD_RF;
   assign forwardbe = init_r ? fwd_b_s : FWD_RF;
   assign stallf    = stallf_s;
   assign stalld    = stalld_s;
   assign stalle    = stalle_s;
   assign stallm    = stallm_s;
   assign flushd    = flushd_s;
   assign flushe    = flushe_s;
   assign flushm    = flushm_s;
   assign flushw    = flushw_s;
   assign mc_go     = mc_go_s;
   assign mc_err    = mc_err_s;

`ifdef HAZARD_PERF_EN
   localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

   logic [PERF_W-1:0] perf_stall_r;
   logic [PERF_W-1:0] perf_flush_r;
   logic [PERF_W-1:0] perf_mc_r;

   // Saturating event counters; reset-held bubbles are not pipeline events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_r <= {PERF_W{1'b0}};
         perf_flush_r <= {PERF_W{1'b0}};
         perf_mc_r    <= {PERF_W{1'b0}};
      end else begin
         if (init_r && stallf_s && (perf_stall_r != PERF_MAX)) begin
            perf_stall_r <= perf_stall_r + PERF_W'(1);
         end else begin
            perf_stall_r <= perf_stall_r;
         end
         if (init_r && (flushd_s || flushe_s) && (perf_flush_r != PERF_MAX)) begin
            perf_flush_r <= perf_flush_r + PERF_W'(1);
         end else begin
            perf_flush_r <= perf_flush_r;
         end
         if ((state_r == ST_MC_WAIT) && (perf_mc_r != PERF_MAX)) begin
            perf_mc_r <= perf_mc_r + PERF_W'(1);
         end else begin
            perf_mc_r <= perf_mc_r;
         end
      end
   end

   assign perf_stall = perf_stall_r;
   assign perf_flush = perf_flush_r;
   assign perf_mc    = perf_mc_r;
`else
   assign perf_stall = {PERF_W{1'b0}};
   assign perf_flush = {PERF_W{1'b0}};
   assign perf_mc    = {PERF_W{1'b0}};
`endif

endmodule
